// File: rtl/seg_shift_ctrl_if.sv
// rtl/seg_shift_ctrl_if.sv - segment-chain controller bus: image/start in, serial chain and status out
interface seg_shift_ctrl_if;
  logic [63:0] seg_txt;
  logic        start;
  logic        flash;
  logic        seg_clk;
  logic        seg_sout;
  logic        seg_latch;
  logic        busy;
  logic        done;

  modport master (
    output seg_txt, start,
    input  flash, seg_clk, seg_sout, seg_latch, busy, done
  );

  modport slave (
    input  seg_txt, start,
    output flash, seg_clk, seg_sout, seg_latch, busy, done
  );
endinterface

// File: rtl/seg_shift_ctrl.sv
// rtl/seg_shift_ctrl.sv - 64-bit segment image serializer with latch pulse and blink clock
// Optional feature macro: SEG_AUTO_REFRESH_EN (resend the image whenever it changes).
module seg_shift_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int FLASH_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_shift_ctrl_if.slave  bus
);

  localparam int DIV_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_ONE    = 1;
  localparam logic [DIV_W-1:0]   HALF       = CLK_DIV;
  localparam logic [DIV_W-1:0]   BIT_LAST   = 2 * CLK_DIV - 1;
  localparam logic [DIV_W-1:0]   LATCH_LAST = CLK_DIV - 1;
  localparam logic [FLASH_W-1:0] FLASH_ONE  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        shadow_q, shadow_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               seg_clk_q, seg_clk_d;
  logic               seg_sout_q, seg_sout_d;
  logic               seg_latch_q, seg_latch_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_req;
  logic               frame_go;

`ifdef SEG_AUTO_REFRESH_EN
  logic [63:0] last_q, last_d;
  logic        pending_q, pending_d;

  assign start_req = bus.start | pending_q;

  // The compare register tracks what was actually captured, so a change
  // arriving mid-frame leaves pending set and triggers the next frame.
  always_comb begin
    last_d    = last_q;
    pending_d = pending_q | (bus.seg_txt != last_q);
    if (frame_go) begin
      last_d    = bus.seg_txt;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end
`else
  assign start_req = bus.start;
`endif

  assign frame_go = (state_q == IDLE) && start_req;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bit_cnt_d   = bit_cnt_q;
    div_d       = div_q;
    flash_cnt_d = flash_cnt_q + FLASH_ONE;

    case (state_q)
      IDLE: begin
        if (frame_go) begin
          state_d   = SHIFT;
          shadow_d  = bus.seg_txt;
          bit_cnt_d = 6'd0;
          div_d     = '0;
        end
      end
      SHIFT: begin
        if (div_q == BIT_LAST) begin
          div_d     = '0;
          shadow_d  = {shadow_q[62:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd63) begin
            state_d = LATCH;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      LATCH: begin
        if (div_q == LATCH_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase

    // Outputs are decoded from next-state values so that every pin is a flop
    // yet still lines up with the cycle the state actually occupies.
    seg_clk_d   = (state_d == SHIFT) && (div_d >= HALF);
    seg_sout_d  = (state_d == SHIFT) && shadow_d[63];
    seg_latch_d = (state_d == LATCH);
    busy_d      = (state_d != IDLE);
    done_d      = (state_q == LATCH) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      div_q       <= '0;
      flash_cnt_q <= '0;
      seg_clk_q   <= 1'b0;
      seg_sout_q  <= 1'b0;
      seg_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      div_q       <= div_d;
      flash_cnt_q <= flash_cnt_d;
      seg_clk_q   <= seg_clk_d;
      seg_sout_q  <= seg_sout_d;
      seg_latch_q <= seg_latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.flash     = flash_cnt_q[FLASH_W-1];
  assign bus.seg_clk   = seg_clk_q;
  assign bus.seg_sout  = seg_sout_q;
  assign bus.seg_latch = seg_latch_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seg_shift_ctrl.sv
// tb/tb_seg_shift_ctrl.sv - scoreboard bench for seg_shift_ctrl at CLK_DIV=2 and CLK_DIV=1
module tb_seg_shift_ctrl;
  localparam int D    = 2;
  localparam int D1   = 1;
  localparam int FLEN = 129 * D + 1;

  typedef struct {
    logic [63:0] data;
    int          done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_shift_ctrl_if s0 ();
  seg_shift_ctrl_if s1 ();

  seg_shift_ctrl #(.CLK_DIV(D), .FLASH_W(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(s0));
  seg_shift_ctrl #(.CLK_DIV(D1), .FLASH_W(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(s1));

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t exp_q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame monitor for u0: rebuilds the image from seg_clk rising edges.
  logic [63:0] cap;
  int   nbits, nlatch, nbusy, done_cnt;
  logic prev_sclk;
  exp_t e_m;
  initial begin
    cap = '0; nbits = 0; nlatch = 0; nbusy = 0; done_cnt = 0; prev_sclk = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cap = '0; nbits = 0; nlatch = 0; nbusy = 0; prev_sclk = 1'b0;
    end else begin
      if (s0.seg_clk && !prev_sclk) begin
        cap = {cap[62:0], s0.seg_sout};
        nbits++;
      end
      prev_sclk = s0.seg_clk;
      if (s0.seg_latch) nlatch++;
      if (s0.busy) nbusy++;
      if (s0.done) begin
        done_cnt++;
        check_eq("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e_m = exp_q.pop_front();
          check_eq("frame_data", cap, e_m.data);
          check_eq("frame_bits", nbits, 64);
          check_eq("latch_len", nlatch, D);
          check_eq("busy_len", nbusy, 129 * D);
          check_eq("done_cycle", cyc, e_m.done_cyc);
          check_eq("busy_at_done", s0.busy, 0);
        end
        cap = '0; nbits = 0; nlatch = 0; nbusy = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frame0(input logic [63:0] data);
    s0.seg_txt = data;
    s0.start   = 1'b1;
    exp_q.push_back('{data, cyc + FLEN});
    step(1);
    s0.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n;
    n = 0;
    while (done_cnt < target && n < limit) begin
      step(1);
      n++;
    end
    check_eq("done_in_time", done_cnt >= target, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   rel, base, nb, n, last_rise, bad, got;
    logic prev;
    logic [63:0] c1;
    exp_t e1;

    s0.seg_txt = '0; s0.start = 1'b0;
    s1.seg_txt = '0; s1.start = 1'b0;
    rst_n = 1'b0;
    step(3);
    check_eq("rst_busy", s0.busy, 0);
    check_eq("rst_flash", s0.flash, 0);
    rst_n = 1'b1;
    rel = cyc;

    // Blink clock: with FLASH_W=4 it toggles every 8 cycles from reset.
    for (int i = 0; i < 40; i++) begin
      step(1);
      check_eq("flash", s0.flash, ((cyc - rel) >> 3) & 1);
    end

    // Asynchronous reset at bit 20 of a frame.
    frame0(64'hDEAD_BEEF_0123_4567);
    step(20 * 2 * D);
    check_eq("busy_midframe", s0.busy, 1);
    base = done_cnt;
    rst_n = 1'b0;
    s0.seg_txt = '0;
    #1;
    check_eq("rst_seg_clk", s0.seg_clk, 0);
    check_eq("rst_seg_sout", s0.seg_sout, 0);
    check_eq("rst_seg_latch", s0.seg_latch, 0);
    check_eq("rst_busy_mid", s0.busy, 0);
    check_eq("rst_done", s0.done, 0);
    check_eq("rst_flash_mid", s0.flash, 0);
    exp_q.delete();
    step(2);
    rst_n = 1'b1;
    nb = 0;
    repeat (1000) begin
      step(1);
      if (s0.busy) nb++;
    end
    check_eq("idle_after_reset", nb, 0);
    check_eq("no_done_after_reset", done_cnt, base);

`ifdef SEG_AUTO_REFRESH_EN
    s0.seg_txt = 64'h1;
    exp_q.push_back('{64'h1, cyc + FLEN + 1});
    wait_done(done_cnt + 1, 400);
    step(5);
    s0.seg_txt = 64'h2;
    exp_q.push_back('{64'h2, cyc + FLEN + 1});
    base = done_cnt;
    wait_done(base + 1, 400);
    step(400);
    check_eq("auto_single_frame", done_cnt, base + 1);

    s0.seg_txt = 64'h3;
    n = cyc + FLEN + 1;
    exp_q.push_back('{64'h3, n});
    base = done_cnt;
    step(2 + 10 * 2 * D);
    s0.seg_txt = 64'h4;
    exp_q.push_back('{64'h4, n + FLEN});
    wait_done(base + 2, 800);
    step(400);
    check_eq("auto_two_frames", done_cnt, base + 2);
`else
    // Single frame, done at T+259.
    frame0(64'hA5A5_0000_FFFF_0F0F);
    wait_done(done_cnt + 1, 400);
    step(3);

    // Shadow copy survives seg_txt change at bit 10.
    frame0(64'hFFFF_FFFF_FFFF_FFFF);
    step(10 * 2 * D);
    s0.seg_txt = '0;
    wait_done(done_cnt + 1, 400);
    step(3);

    // Start pulses at bits 5 and 40 are ignored.
    base = done_cnt;
    frame0(64'h1234_5678_9ABC_DEF0);
    step(5 * 2 * D);
    s0.start = 1'b1;
    step(1);
    s0.start = 1'b0;
    step(35 * 2 * D);
    s0.start = 1'b1;
    step(1);
    s0.start = 1'b0;
    wait_done(base + 1, 400);
    step(300);
    check_eq("start_while_busy", done_cnt, base + 1);

    // Start held high: frames every 129D+1 cycles.
    base = done_cnt;
    s0.seg_txt = 64'hC3C3_3C3C_0FF0_F00F;
    for (int k = 0; k < 3; k++) exp_q.push_back('{64'hC3C3_3C3C_0FF0_F00F, cyc + (k + 1) * FLEN});
    s0.start = 1'b1;
    wait_done(base + 2, 700);
    s0.start = 1'b0;
    wait_done(base + 3, 400);
    step(300);
    check_eq("back_to_back_count", done_cnt, base + 3);

    // Without auto refresh an image change alone starts nothing.
    base = done_cnt;
    s0.seg_txt = 64'h55;
    nb = 0;
    repeat (300) begin
      step(1);
      if (s0.busy) nb++;
    end
    check_eq("no_auto_frame", nb, 0);
    check_eq("no_auto_done", done_cnt, base);

    // CLK_DIV=1 instance: seg_clk period 2, done at T+130.
    s1.seg_txt = 64'h0123_4567_89AB_CDEF;
    s1.start   = 1'b1;
    exp_q1.push_back('{64'h0123_4567_89AB_CDEF, cyc + 129 * D1 + 1});
    step(1);
    s1.start = 1'b0;
    prev = 1'b0; c1 = '0; nb = 0; last_rise = -1; bad = 0; got = 0; n = 0;
    while (got == 0 && n < 300) begin
      if (s1.seg_clk && !prev) begin
        c1 = {c1[62:0], s1.seg_sout};
        nb++;
        if (last_rise >= 0 && cyc - last_rise != 2) bad++;
        last_rise = cyc;
      end
      prev = s1.seg_clk;
      if (s1.done) begin
        got = 1;
        e1 = exp_q1.pop_front();
        check_eq("d1_data", c1, e1.data);
        check_eq("d1_bits", nb, 64);
        check_eq("d1_done_cycle", cyc, e1.done_cyc);
      end else begin
        step(1);
        n++;
      end
    end
    check_eq("d1_done_seen", got, 1);
    check_eq("d1_clk_period", bad, 0);
`endif

    step(5);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
